// File: rtl/fcvt_int_writeback_if.sv
// Handshake bundle between the float-to-int converter, this writeback stage and its consumer.
// The master side drives converter results and consumer ready; the slave side is the stage.
interface fcvt_int_writeback_if #(
   parameter int XLEN = 64,
   parameter int TAGW = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_int;
   logic [2:0]      in_xflags;
   logic            in_word;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [4:0]      out_fflags;
   logic [TAGW-1:0] out_tag;

   modport master (
      output in_valid, in_int, in_xflags, in_word, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_fflags, out_tag
   );

   modport slave (
      input  in_valid, in_int, in_xflags, in_word, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_fflags, out_tag
   );
endinterface

// File: rtl/fcvt_int_writeback.sv
// Float-to-int writeback: RISC-V width formatting, fflags mapping, 2-entry result FIFO
// and a sticky fflags accumulator.
//
// state | meaning
// EMPTY | no buffered results, out_valid=0, in_ready=1
// ONE   | one result buffered, out_valid=1, in_ready=1
// FULL  | two results buffered, out_valid=1, in_ready=0
module fcvt_int_writeback #(
   parameter int XLEN = 64,
   parameter int TAGW = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fcvt_int_writeback_if.slave       bus,
   input  logic                      acc_clear,
   output logic [4:0]                acc_fflags
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state;
   logic            wr_ptr;
   logic            rd_ptr;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [XLEN-1:0] mem_data   [2];
   logic [4:0]      mem_fflags [2];
   logic [TAGW-1:0] mem_tag    [2];

   logic            push;
   logic            pop;
   logic [XLEN-1:0] fmt_data;
   logic            nv;
   logic [4:0]      fmt_fflags;

   assign push = bus.in_valid & in_ready_q;
   assign pop  = out_valid_q & bus.out_ready;

   // Word conversions sign-extend bit 31 regardless of signedness.
   assign fmt_data   = bus.in_word ? {{(XLEN-32){bus.in_int[31]}}, bus.in_int[31:0]} : bus.in_int;
   assign nv         = bus.in_xflags[2] | bus.in_xflags[1];
   assign fmt_fflags = {nv, 3'b000, bus.in_xflags[0] & ~nv};

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = mem_data[rd_ptr];
   assign bus.out_fflags = mem_fflags[rd_ptr];
   assign bus.out_tag    = mem_tag[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= EMPTY;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         acc_fflags  <= 5'd0;
         for (int i = 0; i < 2; i++) begin
            mem_data[i]   <= '0;
            mem_fflags[i] <= '0;
            mem_tag[i]    <= '0;
         end
      end else begin
         if (push) begin
            mem_data[wr_ptr]   <= fmt_data;
            mem_fflags[wr_ptr] <= fmt_fflags;
            mem_tag[wr_ptr]    <= bus.in_tag;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end

         // Clear takes effect before the popped entry is OR-ed in.
         if (acc_clear) begin
            acc_fflags <= pop ? mem_fflags[rd_ptr] : 5'd0;
         end else if (pop) begin
            acc_fflags <= acc_fflags | mem_fflags[rd_ptr];
         end

         case (state)
            EMPTY: begin
               if (push) begin
                  state       <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state      <= FULL;
                  in_ready_q <= 1'b0;
               end else if (pop && !push) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state      <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fcvt_int_writeback.sv
// Bench for fcvt_int_writeback: vector table plus hand-written backpressure, streaming,
// accumulator and reset sequences, all cross-checked against a scoreboard model.
module tb_fcvt_int_writeback;
   localparam int XLEN = 64;
   localparam int TAGW = 5;

   typedef struct {
      logic [XLEN-1:0] in_int;
      logic [2:0]      xflags;
      logic            word;
      logic [TAGW-1:0] tag;
      logic [XLEN-1:0] exp_data;
      logic [4:0]      exp_fflags;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] data;
      logic [4:0]      fflags;
      logic [TAGW-1:0] tag;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       acc_clear;
   logic [4:0] acc_fflags;

   fcvt_int_writeback_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

   fcvt_int_writeback #(.XLEN(XLEN), .TAGW(TAGW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .acc_clear  (acc_clear),
      .acc_fflags (acc_fflags)
   );

   always #5 clk = ~clk;

   int     n_tests = 0;
   int     n_fail  = 0;
   entry_t sb[$];
   int     mcount  = 0;
   logic [4:0] macc = 5'd0;
   bit     armed   = 1'b0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic entry_t model(input logic [XLEN-1:0] x, input logic [2:0] xf,
                                    input logic w, input logic [TAGW-1:0] t);
      entry_t e;
      logic   inv;
      e.data   = w ? {{32{x[31]}}, x[31:0]} : x;
      inv      = xf[2] | xf[1];
      e.fflags = {inv, 3'b000, xf[0] & ~inv};
      e.tag    = t;
      return e;
   endfunction

   // Scoreboard / cycle model, evaluated mid-cycle for the upcoming rising edge.
   always @(negedge clk) begin
      bit mpop;
      bit mpush;
      entry_t h;
      if (armed) begin
         check("in_ready", {63'd0, bus.in_ready}, {63'd0, mcount != 2});
         check("out_valid", {63'd0, bus.out_valid}, {63'd0, mcount != 0});
         check("acc_fflags", {59'd0, acc_fflags}, {59'd0, macc});
      end
      if (!rst_n) begin
         sb.delete();
         mcount = 0;
         macc   = 5'd0;
         armed  = 1'b1;
      end else if (armed) begin
         mpop  = (mcount != 0) && bus.out_ready;
         mpush = bus.in_valid && (mcount != 2);
         h = '{default: '0};
         if (mpop) begin
            h = sb.pop_front();
            check("out_data", bus.out_data, h.data);
            check("out_fflags", {59'd0, bus.out_fflags}, {59'd0, h.fflags});
            check("out_tag", {59'd0, bus.out_tag}, {59'd0, h.tag});
         end
         if (acc_clear) macc = mpop ? h.fflags : 5'd0;
         else if (mpop) macc = macc | h.fflags;
         if (mpush) sb.push_back(model(bus.in_int, bus.in_xflags, bus.in_word, bus.in_tag));
         mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [XLEN-1:0] x, input logic [2:0] xf,
                        input logic w, input logic [TAGW-1:0] t);
      bus.in_valid  = v;
      bus.in_int    = x;
      bus.in_xflags = xf;
      bus.in_word   = w;
      bus.in_tag    = t;
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{64'h0000_0000_8000_0001, 3'b000, 1'b1, 5'd1, 64'hFFFF_FFFF_8000_0001, 5'b00000};
      vecs[1] = '{64'h1234_5678_9ABC_DEF0, 3'b011, 1'b0, 5'd2, 64'h1234_5678_9ABC_DEF0, 5'b10000};
      vecs[2] = '{64'hDEAD_BEEF_7FFF_FFFF, 3'b001, 1'b1, 5'd3, 64'h0000_0000_7FFF_FFFF, 5'b00001};
      vecs[3] = '{64'h8000_0000_0000_0000, 3'b100, 1'b0, 5'd4, 64'h8000_0000_0000_0000, 5'b10000};
      vecs[4] = '{64'hFFFF_FFFF_0000_0000, 3'b101, 1'b1, 5'd5, 64'h0000_0000_0000_0000, 5'b10000};
      vecs[5] = '{64'h0000_0000_0000_0000, 3'b010, 1'b0, 5'd6, 64'h0000_0000_0000_0000, 5'b10000};
      vecs[6] = '{64'h0000_0001_FFFF_FFFE, 3'b111, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'b10000};
      vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 5'd8, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00001};

      rst_n = 1'b0;
      acc_clear = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst acc", {59'd0, acc_fflags}, 64'd0);
      check("rst out_data", bus.out_data, 64'd0);
      check("rst out_fflags", {59'd0, bus.out_fflags}, 64'd0);
      check("rst out_tag", {59'd0, bus.out_tag}, 64'd0);

      // Table: push into empty FIFO, check head one cycle later, then pop.
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].in_int, vecs[i].xflags, vecs[i].word, vecs[i].tag);
         step();
         drive(1'b0, '0, 3'b000, 1'b0, '0);
         check("vec valid", {63'd0, bus.out_valid}, 64'd1);
         check("vec data", bus.out_data, vecs[i].exp_data);
         check("vec fflags", {59'd0, bus.out_fflags}, {59'd0, vecs[i].exp_fflags});
         check("vec tag", {59'd0, bus.out_tag}, {59'd0, vecs[i].tag});
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
      end

      // Backpressure: tags 3, 7 fill the FIFO, tag 9 must be refused.
      drive(1'b1, 64'd300, 3'b000, 1'b0, 5'd3);
      step();
      drive(1'b1, 64'd700, 3'b000, 1'b0, 5'd7);
      step();
      check("bp in_ready low", {63'd0, bus.in_ready}, 64'd0);
      drive(1'b1, 64'd900, 3'b001, 1'b0, 5'd9);
      step();
      step();
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      check("bp head tag3", {59'd0, bus.out_tag}, 64'd3);
      bus.out_ready = 1'b1;
      step();
      check("bp in_ready back", {63'd0, bus.in_ready}, 64'd1);
      check("bp head tag7", {59'd0, bus.out_tag}, 64'd7);
      step();
      check("bp drained", {63'd0, bus.out_valid}, 64'd0);

      // Streaming: continuous push with pop, count stays at one.
      for (int t = 10; t < 16; t++) begin
         drive(1'b1, 64'(t) << 20, 3'(t % 3), 1'(t % 2), 5'(t));
         step();
         check("stream valid", {63'd0, bus.out_valid}, 64'd1);
         check("stream ready", {63'd0, bus.in_ready}, 64'd1);
         check("stream head tag", {59'd0, bus.out_tag}, 64'(t));
      end
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      step();
      check("stream drained", {63'd0, bus.out_valid}, 64'd0);
      bus.out_ready = 1'b0;

      // Accumulator: clear alone, then NX + NV pops.
      acc_clear = 1'b1;
      step();
      acc_clear = 1'b0;
      check("acc cleared", {59'd0, acc_fflags}, 64'd0);
      drive(1'b1, 64'd1, 3'b001, 1'b0, 5'd20);
      step();
      drive(1'b1, 64'd2, 3'b100, 1'b0, 5'd21);
      step();
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      bus.out_ready = 1'b1;
      step();
      step();
      bus.out_ready = 1'b0;
      check("acc nx|nv", {59'd0, acc_fflags}, 64'b10001);

      // Clear coinciding with an NX pop keeps only that entry's flags.
      drive(1'b1, 64'd3, 3'b001, 1'b1, 5'd22);
      step();
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      bus.out_ready = 1'b1;
      acc_clear = 1'b1;
      step();
      bus.out_ready = 1'b0;
      acc_clear = 1'b0;
      check("acc clear+pop", {59'd0, acc_fflags}, 64'b00001);

      // Mid-stream reset with a push attempt in the reset cycle.
      drive(1'b1, 64'd5, 3'b010, 1'b0, 5'd23);
      step();
      drive(1'b1, 64'd6, 3'b001, 1'b0, 5'd24);
      step();
      drive(1'b1, 64'd7, 3'b001, 1'b0, 5'd25);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, '0, 3'b000, 1'b0, '0);
      check("mrst out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mrst in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("mrst acc", {59'd0, acc_fflags}, 64'd0);
      check("mrst out_data", bus.out_data, 64'd0);
      step();
      check("mrst still empty", {63'd0, bus.out_valid}, 64'd0);
      check("scoreboard empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
